pic_inta_sequencer: RTL and testbench

- Downstream stage of the 8259 priority block: consumes PRIORITY_MODE/PRIORITY_DATA, raises INT to the CPU and runs the two-pulse INTA handshake.
- On the second INTA it drives the 8-bit vector {ICW2[7:3], level}.
- Feeds acknowledge commands back to the priority block as CU_MODE = 3'b110 with a one-cycle CU_WRITE strobe.
- Clocked replacement for the asynchronous acknowledge path; sits between the priority block and the CPU bus interface.

---
 rtl/pic_pkg.sv | 15 +
 rtl/pic_inta_sync.sv | 14 +
 rtl/pic_inta_sequencer.sv | 129 ++++++++++++
 tb/tb_pic_inta_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// pic_pkg: shared command codes, acknowledge-sequencer states and defaults for the 8259 blocks
package pic_pkg;
  localparam logic [2:0] PIC_MODE_IRR    = 3'b000;
  localparam logic [2:0] PIC_MODE_ISR    = 3'b001;
  localparam logic [2:0] PIC_MODE_IMR    = 3'b010;
  localparam logic [2:0] PIC_MODE_OCW2   = 3'b011;
  localparam logic [2:0] PIC_MODE_ICW    = 3'b100;
  localparam logic [2:0] PIC_MODE_HANDLE = 3'b101;
  localparam logic [2:0] PIC_MODE_ACK    = 3'b110;
  localparam logic [2:0] PIC_MODE_RST    = 3'b111;
  localparam int PIC_SPURIOUS_LEVEL = 7;
  typedef enum logic [2:0] {
    ST_IDLE, ST_ASSERT, ST_ACK1, ST_GAP, ST_ACK2, ST_DONE, ST_POLL
  } pic_inta_state_t;
endpackage

// File: rtl/pic_inta_sync.sv
// pic_inta_sync: 2-FF synchroniser plus edge register on INTA_N, producing single-cycle fall/rise flags
module pic_inta_sync (
  input  logic CLK,
  input  logic RST_N,
  input  logic inta_n,
  output logic fall,
  output logic rise
);
  logic [2:0] sr;
  always_ff @(posedge CLK)
    sr <= !RST_N ? 3'b111 : {sr[1:0], inta_n};
  assign fall = sr[2] & ~sr[1];
  assign rise = ~sr[2] & sr[1];
endmodule

// File: rtl/pic_inta_sequencer.sv
// pic_inta_sequencer: raises INT and runs the two-pulse INTA handshake, driving {ICW2[7:3], level}.
// Define PIC_POLL_EN to add the POLL_REQ / POLL_VALID poll-command path.
module pic_inta_sequencer
  import pic_pkg::*;
#(
  parameter int INTA_TIMEOUT   = 1023,
  parameter int SPURIOUS_LEVEL = PIC_SPURIOUS_LEVEL
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] PRIORITY_DATA,
  input  logic [2:0] PRIORITY_MODE,
  input  logic       ICW2_WRITE,
  input  logic [7:0] ICW2_DATA,
  input  logic       INTA_N,
  output logic       INT,
  output logic [2:0] CU_MODE,
  output logic       CU_WRITE,
  output logic [7:0] DATA_OUT,
  output logic       DATA_OE,
  output logic       BUSY,
  output logic       SPURIOUS,
  output logic       TIMEOUT
`ifdef PIC_POLL_EN
  ,
  input  logic       POLL_REQ,
  output logic       POLL_VALID
`endif
);
  localparam int CW = $clog2(INTA_TIMEOUT + 1);
  pic_inta_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0] icw2, vbase, vbase_n, data_n;
  logic [2:0] level, level_n;
  logic spur, spur_n, cu_write_n, spurious_n, timeout_n, poll_valid, poll_valid_n;
  logic fall, rise, pending, tmo;
  pic_inta_sync u_sync (.CLK(CLK), .RST_N(RST_N), .inta_n(INTA_N), .fall(fall), .rise(rise));
  assign pending = PRIORITY_MODE == PIC_MODE_ACK;
  assign tmo = cnt == CW'(INTA_TIMEOUT - 1);
  always_ff @(posedge CLK)
    if (!RST_N) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      icw2       <= '0;
      vbase      <= '0;
      level      <= '0;
      spur       <= 1'b0;
      DATA_OUT   <= '0;
      CU_WRITE   <= 1'b0;
      SPURIOUS   <= 1'b0;
      TIMEOUT    <= 1'b0;
      poll_valid <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      icw2       <= ICW2_WRITE ? ICW2_DATA : icw2;
      vbase      <= vbase_n;
      level      <= level_n;
      spur       <= spur_n;
      DATA_OUT   <= data_n;
      CU_WRITE   <= cu_write_n;
      SPURIOUS   <= spurious_n;
      TIMEOUT    <= timeout_n;
      poll_valid <= poll_valid_n;
    end
  always_comb begin
    state_n      = state;
    vbase_n      = vbase;
    level_n      = level;
    spur_n       = spur;
    data_n       = DATA_OUT;
    cu_write_n   = 1'b0;
    spurious_n   = 1'b0;
    timeout_n    = 1'b0;
    poll_valid_n = 1'b0;
    case (state)
      ST_IDLE:   state_n = pending ? ST_ASSERT : ST_IDLE;
      ST_ASSERT:
        if (fall) begin
          level_n    = pending ? PRIORITY_DATA[2:0] : 3'(SPURIOUS_LEVEL);
          spur_n     = !pending;
          vbase_n    = ICW2_WRITE ? ICW2_DATA : icw2;
          cu_write_n = pending;
          state_n    = ST_ACK1;
        end else if (tmo) begin
          timeout_n = 1'b1;
          state_n   = ST_IDLE;
        end
      ST_ACK1:   state_n = rise ? ST_GAP : ST_ACK1;
      ST_GAP:
        if (fall) begin
          cu_write_n = !spur;
          data_n     = {vbase[7:3], level};
          state_n    = ST_ACK2;
        end else if (tmo) begin
          timeout_n = 1'b1;
          state_n   = ST_IDLE;
        end
      ST_ACK2:
        if (rise) begin
          spurious_n = spur;
          state_n    = ST_DONE;
        end
      ST_POLL: begin
        cu_write_n = 1'b1;
        state_n    = ST_DONE;
      end
      default:   state_n = ST_IDLE;
    endcase
`ifdef PIC_POLL_EN
    if (POLL_REQ && (state == ST_IDLE || state == ST_ASSERT)) begin
      data_n       = {pending, 4'b0000, pending ? PRIORITY_DATA[2:0] : 3'(SPURIOUS_LEVEL)};
      poll_valid_n = 1'b1;
      cu_write_n   = pending;
      timeout_n    = 1'b0;
      state_n      = pending ? ST_POLL : ST_IDLE;
    end
`endif
    // the counter restarts on every state change, so ACK1 -> GAP begins from zero
    cnt_n = (state_n == state && (state == ST_ASSERT || state == ST_GAP)) ? cnt + 1'b1 : '0;
  end
  assign INT     = state inside {ST_ASSERT, ST_ACK1, ST_GAP, ST_ACK2};
  assign BUSY    = state != ST_IDLE;
  assign DATA_OE = (state == ST_ACK2) | poll_valid;
  assign CU_MODE = CU_WRITE ? PIC_MODE_ACK : PIC_MODE_IRR;
`ifdef PIC_POLL_EN
  assign POLL_VALID = poll_valid;
`endif
endmodule

// File: tb/tb_pic_inta_sequencer.sv
// tb_pic_inta_sequencer: table-driven and randomized INTA handshakes checked against a transaction-level model
module tb_pic_inta_sequencer;
  logic CLK = 1'b0, RST_N = 1'b0;
  logic [7:0] PRIORITY_DATA = '0, ICW2_DATA = '0, DATA_OUT;
  logic [2:0] PRIORITY_MODE = '0, CU_MODE;
  logic ICW2_WRITE = 1'b0, INTA_N = 1'b1;
  logic INT, CU_WRITE, DATA_OE, BUSY, SPURIOUS, TIMEOUT;
  int vectors = 0, miscompares = 0;
  int cu_tot = 0, spur_tot = 0, tmo_tot = 0, oe_tot = 0, mode_err = 0;
  logic [7:0] last_vec = '0;

  pic_inta_sequencer #(.INTA_TIMEOUT(15)) dut (
    .CLK(CLK), .RST_N(RST_N), .PRIORITY_DATA(PRIORITY_DATA), .PRIORITY_MODE(PRIORITY_MODE),
    .ICW2_WRITE(ICW2_WRITE), .ICW2_DATA(ICW2_DATA), .INTA_N(INTA_N), .INT(INT),
    .CU_MODE(CU_MODE), .CU_WRITE(CU_WRITE), .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE),
    .BUSY(BUSY), .SPURIOUS(SPURIOUS), .TIMEOUT(TIMEOUT)
  );

  always #5 CLK = ~CLK;

  // bus monitor: tallies pulses and captures the vector while it is driven
  always @(negedge CLK) begin
    if (CU_WRITE) cu_tot++;
    if (SPURIOUS) spur_tot++;
    if (TIMEOUT) tmo_tot++;
    if (DATA_OE) begin
      oe_tot++;
      last_vec = DATA_OUT;
    end
    if (CU_WRITE ? CU_MODE !== 3'b110 : CU_MODE !== 3'b000) mode_err++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1);
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // reference: vector is the base latched at the first acknowledge with the frozen level
  function automatic logic [7:0] model_vec(input logic [7:0] base, input logic [2:0] lvl, input bit drop);
    return (base & 8'hF8) + (drop ? 8'd7 : 8'(lvl));
  endfunction

  task automatic run_txn(input string name, input logic [7:0] icw2, input logic [2:0] lvl,
                         input logic [2:0] lvl2, input bit drop, input bit rewrite, input bit wr_fall,
                         input int w1, input int g, input int w2,
                         input logic [7:0] exp_vec, input int exp_cu, input int exp_spur);
    int c0, s0, o0, t0;
    ICW2_DATA = icw2;
    ICW2_WRITE = 1'b1;
    tick();
    ICW2_WRITE = 1'b0;
    PRIORITY_DATA = {5'($urandom), lvl};
    PRIORITY_MODE = 3'b110;
    tick();
    chk({name, " int_rise"}, INT, 1);
    if (drop) PRIORITY_MODE = 3'b000;
    c0 = cu_tot; s0 = spur_tot; o0 = oe_tot; t0 = tmo_tot;
    INTA_N = 1'b0;
    for (int k = 0; k < w1; k++) begin
      if (wr_fall && k == 2) begin
        ICW2_DATA = 8'h90;
        ICW2_WRITE = 1'b1;
      end
      tick();
      ICW2_WRITE = 1'b0;
    end
    INTA_N = 1'b1;
    repeat (g) tick();
    if (rewrite) begin
      ICW2_DATA = 8'h80;
      ICW2_WRITE = 1'b1;
      tick();
      ICW2_WRITE = 1'b0;
    end
    PRIORITY_DATA[2:0] = lvl2;
    INTA_N = 1'b0;
    repeat (w2) tick();
    INTA_N = 1'b1;
    PRIORITY_MODE = 3'b000;
    for (int i = 0; i < 30 && BUSY; i++) tick();
    chk({name, " cu_writes"}, cu_tot - c0, exp_cu);
    chk({name, " spurious"}, spur_tot - s0, exp_spur);
    chk({name, " vector_driven"}, (oe_tot - o0) > 0, 1);
    chk({name, " vector"}, last_vec, exp_vec);
    chk({name, " int_low"}, {INT, BUSY, DATA_OE}, 0);
    chk({name, " no_timeout"}, tmo_tot - t0, 0);
  endtask

  typedef struct {
    string name;
    logic [7:0] icw2;
    logic [2:0] lvl, lvl2;
    bit drop, rewrite, wr_fall;
    logic [7:0] exp_vec;
    int exp_cu, exp_spur;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int c0;
    tbl[0] = '{"basic", 8'h40, 3'd3, 3'd3, 0, 0, 0, 8'h43, 2, 0};
    tbl[1] = '{"spurious", 8'h40, 3'd3, 3'd3, 1, 0, 0, 8'h47, 0, 1};
    tbl[2] = '{"level_frozen", 8'h40, 3'd3, 3'd1, 0, 0, 0, 8'h43, 2, 0};
    tbl[3] = '{"icw2_frozen", 8'h40, 3'd3, 3'd3, 0, 1, 0, 8'h43, 2, 0};
    tbl[4] = '{"icw2_at_fall", 8'h40, 3'd3, 3'd3, 0, 0, 1, 8'h93, 2, 0};
    tbl[5] = '{"max_level", 8'hF8, 3'd7, 3'd0, 0, 0, 0, 8'hFF, 2, 0};

    repeat (3) tick();
    RST_N = 1'b1;
    tick();
    chk("reset int_busy_oe", {INT, BUSY, DATA_OE}, 0);
    chk("reset pulses", {CU_WRITE, SPURIOUS, TIMEOUT}, 0);
    chk("reset cu_mode", CU_MODE, 3'b000);
    chk("reset data_out", DATA_OUT, 8'h00);

    foreach (tbl[i])
      run_txn(tbl[i].name, tbl[i].icw2, tbl[i].lvl, tbl[i].lvl2, tbl[i].drop, tbl[i].rewrite,
              tbl[i].wr_fall, 4, 3, 4, tbl[i].exp_vec, tbl[i].exp_cu, tbl[i].exp_spur);

    // no acknowledge: INT must stay up for exactly the timeout window
    begin
      int hi = 0;
      int t0 = tmo_tot;
      PRIORITY_MODE = 3'b110;
      tick();
      PRIORITY_MODE = 3'b000;
      for (int i = 0; i < 100 && INT; i++) begin
        hi++;
        tick();
      end
      chk("timeout int_cycles", hi, 15);
      chk("timeout pulse", TIMEOUT, 1);
      chk("timeout idle", {INT, BUSY}, 0);
      tick();
      chk("timeout single_pulse", tmo_tot - t0, 1);
    end

    // reset while waiting for the second acknowledge
    ICW2_DATA = 8'h40;
    ICW2_WRITE = 1'b1;
    tick();
    ICW2_WRITE = 1'b0;
    PRIORITY_DATA = 8'h03;
    PRIORITY_MODE = 3'b110;
    tick();
    c0 = cu_tot;
    INTA_N = 1'b0;
    repeat (4) tick();
    INTA_N = 1'b1;
    repeat (4) tick();
    chk("gap busy", {INT, BUSY}, 2'b11);
    RST_N = 1'b0;
    PRIORITY_MODE = 3'b000;
    tick();
    RST_N = 1'b1;
    chk("gap_reset outputs", {INT, BUSY, DATA_OE, CU_WRITE, SPURIOUS, TIMEOUT}, 0);
    chk("gap_reset data", {CU_MODE, DATA_OUT}, 0);
    repeat (3) tick();
    chk("gap_reset acks", cu_tot - c0, 1);
    run_txn("after_reset", 8'h40, 3'd3, 3'd3, 0, 0, 0, 4, 3, 4, 8'h43, 2, 0);

    for (int n = 0; n < 40; n++) begin
      logic [7:0] b = 8'($urandom);
      logic [2:0] l = 3'($urandom);
      bit d = $urandom_range(0, 3) == 0;
      run_txn($sformatf("rand%0d", n), b, l, 3'($urandom), d, 1'($urandom), 0,
              $urandom_range(2, 6), $urandom_range(2, 6), $urandom_range(2, 6),
              model_vec(b, l, d), d ? 0 : 2, d ? 1 : 0);
    end

    chk("cu_mode protocol", mode_err, 0);
    chk("timeout total", tmo_tot, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
